// File: rtl/hilo_if.sv
// Datapath/multiplier-facing bundle of the HI/LO sequencer: requests, multiplier
// handshake and the architectural register view.
interface hilo_if #(
   parameter int unsigned DATA_W = 32
) ();
   logic              mult_req;
   logic              mthi_we;
   logic              mtlo_we;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] mul_hi;
   logic [DATA_W-1:0] mul_lo;
   logic              mul_clr;
   logic              mul_en;
   logic              rd_req;
   logic              rd_sel;
   logic [DATA_W-1:0] rd_data;
   logic              stall;
   logic              busy;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport slave (
      input  mult_req, mthi_we, mtlo_we, wr_data, mul_hi, mul_lo, rd_req, rd_sel,
      output mul_clr, mul_en, rd_data, stall, busy, hi, lo
   );

   modport master (
      output mult_req, mthi_we, mtlo_we, wr_data, mul_hi, mul_lo, rd_req, rd_sel,
      input  mul_clr, mul_en, rd_data, stall, busy, hi, lo
   );
endinterface

// File: rtl/hilo_sequencer.sv
// Sequences the radix-4 Booth multiplier into HI/LO and services mthi/mtlo/mfhi/mflo.
// Optional macro HILO_BYPASS_EN: forward the multiplier product to reads during CAPTURE.
module hilo_sequencer #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MUL_CYCLES = 16,
   parameter int unsigned CNT_W      = 5
) (
   input logic   clk,
   input logic   rst,
   hilo_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_CAPTURE
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              mul_clr_q, mul_en_q, busy_q;
   logic              rd_stall_c;
   logic [DATA_W-1:0] rd_data_c;

   // Strobes are registered from the next state so they line up with the state they decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         mul_clr_q <= 1'b0;
         mul_en_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         mul_clr_q <= (state_d == S_CLEAR);
         mul_en_q  <= (state_d == S_RUN);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   // mt writes and multiply issue only land in IDLE; while busy they stall and are dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.mthi_we) hi_d = bus.wr_data;
            if (bus.mtlo_we) lo_d = bus.wr_data;
            if (bus.mult_req) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            hi_d    = bus.mul_hi;
            lo_d    = bus.mul_lo;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef HILO_BYPASS_EN
   always_comb begin
      rd_stall_c = bus.rd_req & (state_q != S_CAPTURE);
      if (state_q == S_CAPTURE) rd_data_c = bus.rd_sel ? bus.mul_hi : bus.mul_lo;
      else                      rd_data_c = bus.rd_sel ? hi_q : lo_q;
   end
`else
   always_comb begin
      rd_stall_c = bus.rd_req;
      rd_data_c  = bus.rd_sel ? hi_q : lo_q;
   end
`endif

   assign bus.stall   = busy_q & (rd_stall_c | bus.mult_req | bus.mthi_we | bus.mtlo_we);
   assign bus.rd_data = rd_data_c;
   assign bus.mul_clr = mul_clr_q;
   assign bus.mul_en  = mul_en_q;
   assign bus.busy    = busy_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;

endmodule
